// File: rtl/fsmc_pkg.sv
// Shared types and constants for the MCU external-bus front end.
// - state_t : bus controller FSM states
// - tgt_t   : decoded target of the latched 19-bit address
// - decode(): maps a latched address to its target
package fsmc_pkg;

  typedef enum logic [2:0] {
    IDLE, WR_WAIT, WR_EXEC, RD_REQ, RD_WAIT, RD_DRIVE
  } state_t;

  typedef enum logic [2:0] {
    TGT_NONE, TGT_RAM, TGT_FREWL, TGT_FREWH, TGT_FIFO
  } tgt_t;

  localparam logic [3:0]  ADDR_RAM_TAG = 4'hA;       // ADDR[18:15] of the DDS RAM window
  localparam logic [18:0] ADDR_FREWL   = 19'h58400;
  localparam logic [18:0] ADDR_FREWH   = 19'h58800;
  localparam logic [18:0] ADDR_FIFO    = 19'h58001;

  function automatic tgt_t decode(input logic [18:0] a);
    if (a[18:15] == ADDR_RAM_TAG) return TGT_RAM;
    else if (a == ADDR_FREWL)     return TGT_FREWL;
    else if (a == ADDR_FREWH)     return TGT_FREWH;
    else if (a == ADDR_FIFO)      return TGT_FIFO;
    else                          return TGT_NONE;
  endfunction

endpackage

// File: rtl/fsmc_sync_edge.sv
// Multi-flop synchroniser for one asynchronous strobe, with edge pulses.
// Ports: clk/rst_n (async low reset), din (async input),
//        sync (resynchronised level), rise/fall (one-cycle pulses on the
//        synced copy).
// Flops reset to 0, so a strobe idling high produces a single rise pulse
// after reset release and never a spurious fall.
module fsmc_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sh;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh   <= '0;
      prev <= 1'b0;
    end else begin
      sh   <= {sh[STAGES-2:0], din};
      prev <= sh[STAGES-1];
    end
  end

  assign sync = sh[STAGES-1];
  assign rise = sh[STAGES-1] & ~prev;
  assign fall = ~sh[STAGES-1] & prev;

endmodule

// File: rtl/fsmc_bus_ctrl.sv
// Single-clock front end for the MCU multiplexed external bus.
// Resynchronises NADV/NWE/NOE, latches the 19-bit address on NADV rise and
// sequences DDS RAM writes, the two-halves DDS frequency word, and ADC FIFO
// reads back onto the AD bus.
// Ports:
//   CLK, RST_N            clock, async active-low reset
//   NADV/NWE/NOE          async MCU strobes (active low)
//   A_HI, AD_IN           address high bits / AD bus input
//   AD_OUT, AD_OE         read data and tristate enable to the AD pins
//   RAM_WE/ADDR/WDATA     DDS waveform RAM write port
//   FREQ_WORD, FREQ_UPD   committed frequency word and its update pulse
//   FIFO_RD, FIFO_DATA, FIFO_EMPTY  ADC FIFO read port
module fsmc_bus_ctrl
  import fsmc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WR_SAMPLE   = 2,
  parameter int FIFO_LAT    = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        NADV,
  input  logic        NWE,
  input  logic        NOE,
  input  logic [2:0]  A_HI,
  input  logic [15:0] AD_IN,
  output logic [15:0] AD_OUT,
  output logic        AD_OE,
  output logic        RAM_WE,
  output logic [14:0] RAM_ADDR,
  output logic [15:0] RAM_WDATA,
  output logic [31:0] FREQ_WORD,
  output logic        FREQ_UPD,
  output logic        FIFO_RD,
  input  logic [15:0] FIFO_DATA,
  input  logic        FIFO_EMPTY
);

  localparam int CMAX = (WR_SAMPLE > FIFO_LAT) ? WR_SAMPLE : FIFO_LAT;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] WR_LAST = CW'(WR_SAMPLE - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(FIFO_LAT - 1);

  logic nadv_s, nadv_rise, nadv_fall;
  logic nwe_s, nwe_rise, nwe_fall;
  logic noe_s, noe_rise, noe_fall;

  fsmc_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_nadv (
    .clk(CLK), .rst_n(RST_N), .din(NADV), .sync(nadv_s), .rise(nadv_rise), .fall(nadv_fall));
  fsmc_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_nwe (
    .clk(CLK), .rst_n(RST_N), .din(NWE), .sync(nwe_s), .rise(nwe_rise), .fall(nwe_fall));
  fsmc_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_noe (
    .clk(CLK), .rst_n(RST_N), .din(NOE), .sync(noe_s), .rise(noe_rise), .fall(noe_fall));

  // Edge/level outputs this controller has no use for.
  logic unused;
  assign unused = ^{nadv_s, nwe_rise, noe_rise};

  state_t          state_q, state_d;
  tgt_t            tgt;
  logic [18:0]     addr;
  logic [15:0]     data_q, shadow, ram_wdata_q, ad_out_q, ad_next;
  logic [14:0]     ram_addr_q;
  logic [31:0]     freq_word_q;
  logic            freq_upd_q;
  logic [CW-1:0]   cnt;
  logic            was_exec;
  logic            cnt_clr, cnt_inc, cap_data, ld_shadow, commit, ad_load;
  logic            ram_we, fifo_rd;

  assign tgt = decode(addr);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    cap_data  = 1'b0;
    ld_shadow = 1'b0;
    commit    = 1'b0;
    ad_load   = 1'b0;
    ad_next   = '0;
    ram_we    = 1'b0;
    fifo_rd   = 1'b0;
    case (state_q)
      IDLE: begin
        // write takes priority over a simultaneous read
        if (nwe_fall) begin
          state_d = WR_WAIT;
          cnt_clr = 1'b1;
        end else if (noe_fall) begin
          state_d = RD_REQ;
        end
      end
      WR_WAIT: begin
        if (cnt == WR_LAST) begin
          cap_data = 1'b1;
          state_d  = WR_EXEC;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WR_EXEC: begin
        // side effects only on the first cycle; the rest is waiting for NWE
        if (!was_exec) begin
          case (tgt)
            TGT_RAM:   ram_we    = 1'b1;
            TGT_FREWL: ld_shadow = 1'b1;
            TGT_FREWH: commit    = 1'b1;
            default:   ;
          endcase
        end
        if (nwe_s) state_d = IDLE;
      end
      RD_REQ: begin
        if (tgt == TGT_FIFO && !FIFO_EMPTY) begin
          fifo_rd = 1'b1;
          cnt_clr = 1'b1;
          state_d = RD_WAIT;
        end else begin
          ad_load = 1'b1;
          ad_next = (tgt == TGT_FIFO) ? 16'h0000 : {13'b0, FIFO_EMPTY, 2'b0};
          state_d = RD_DRIVE;
        end
      end
      RD_WAIT: begin
        if (cnt == RD_LAST) begin
          ad_load = 1'b1;
          ad_next = FIFO_DATA;
          state_d = RD_DRIVE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RD_DRIVE: begin
        if (noe_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a new address phase kills any transaction in flight, side effects included
    if (state_q != IDLE && nadv_fall) begin
      state_d   = IDLE;
      cap_data  = 1'b0;
      ld_shadow = 1'b0;
      commit    = 1'b0;
      ad_load   = 1'b0;
      ram_we    = 1'b0;
      fifo_rd   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr        <= '0;
      cnt         <= '0;
      data_q      <= '0;
      shadow      <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      freq_word_q <= '0;
      freq_upd_q  <= 1'b0;
      ad_out_q    <= '0;
      was_exec    <= 1'b0;
    end else begin
      if (nadv_rise) addr <= {A_HI, AD_IN};
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (cap_data) data_q <= AD_IN;
      // RAM port registers only move for RAM writes, so other targets leave them alone
      if (cap_data && tgt == TGT_RAM) begin
        ram_addr_q  <= addr[14:0];
        ram_wdata_q <= AD_IN;
      end
      if (ld_shadow) shadow <= data_q;
      // both halves land in one edge: no half-updated word is ever visible
      if (commit) freq_word_q <= {data_q, shadow};
      freq_upd_q <= commit;
      if (ad_load) ad_out_q <= ad_next;
      was_exec <= (state_q == WR_EXEC);
    end
  end

  assign AD_OUT    = ad_out_q;
  assign AD_OE     = (state_q == RD_DRIVE);
  assign RAM_WE    = ram_we;
  assign RAM_ADDR  = ram_addr_q;
  assign RAM_WDATA = ram_wdata_q;
  assign FREQ_WORD = freq_word_q;
  assign FREQ_UPD  = freq_upd_q;
  assign FIFO_RD   = fifo_rd;

endmodule

// File: tb/tb_fsmc_bus_ctrl.sv
// Directed bench for fsmc_bus_ctrl with a scoreboard of expected RAM writes,
// frequency commits and read-back words.
module tb_fsmc_bus_ctrl;

  logic        CLK = 1'b0, RST_N = 1'b0;
  logic        NADV = 1'b1, NWE = 1'b1, NOE = 1'b1;
  logic [2:0]  A_HI = '0;
  logic [15:0] AD_IN = '0, FIFO_DATA = '0;
  logic        FIFO_EMPTY = 1'b1;
  logic [15:0] AD_OUT, RAM_WDATA;
  logic        AD_OE, RAM_WE, FREQ_UPD, FIFO_RD;
  logic [14:0] RAM_ADDR;
  logic [31:0] FREQ_WORD;

  fsmc_bus_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .NADV(NADV), .NWE(NWE), .NOE(NOE),
    .A_HI(A_HI), .AD_IN(AD_IN), .AD_OUT(AD_OUT), .AD_OE(AD_OE),
    .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA),
    .FREQ_WORD(FREQ_WORD), .FREQ_UPD(FREQ_UPD), .FIFO_RD(FIFO_RD),
    .FIFO_DATA(FIFO_DATA), .FIFO_EMPTY(FIFO_EMPTY));

  always #5 CLK = ~CLK;

  int total = 0, bad = 0;
  int ram_we_cnt = 0, upd_cnt = 0, fifo_rd_cnt = 0;
  logic oe_q = 1'b0;
  logic [30:0] ram_q[$];
  logic [31:0] freq_q[$];
  logic [15:0] rd_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard whenever the DUT produces a result.
  always @(negedge CLK) begin
    if (RAM_WE) begin
      ram_we_cnt <= ram_we_cnt + 1;
      if (ram_q.size() == 0) chk("ram_unexpected", 32'd1, 32'd0);
      else chk("ram_sb", 32'({RAM_ADDR, RAM_WDATA}), 32'(ram_q.pop_front()));
    end
    if (FREQ_UPD) begin
      upd_cnt <= upd_cnt + 1;
      if (freq_q.size() == 0) chk("freq_unexpected", 32'd1, 32'd0);
      else chk("freq_sb", FREQ_WORD, freq_q.pop_front());
    end
    if (AD_OE && !oe_q) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
      else chk("rd_sb", 32'(AD_OUT), 32'(rd_q.pop_front()));
    end
    if (FIFO_RD) fifo_rd_cnt <= fifo_rd_cnt + 1;
    oe_q <= AD_OE;
  end

  task automatic addr_phase(input logic [18:0] a);
    @(negedge CLK);
    NADV = 1'b0; A_HI = a[18:16]; AD_IN = a[15:0];
    repeat (3) @(negedge CLK);
    NADV = 1'b1;
    repeat (5) @(negedge CLK);
  endtask

  task automatic bus_write(input logic [18:0] a, input logic [15:0] d);
    addr_phase(a);
    AD_IN = d; NWE = 1'b0;
    repeat (10) @(negedge CLK);
    NWE = 1'b1;
    repeat (6) @(negedge CLK);
  endtask

  // lat = negedges from NOE low until AD_OE is seen high
  task automatic bus_read(input logic [18:0] a, input int lat);
    int seen = 0;
    addr_phase(a);
    NOE = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge CLK);
      if (AD_OE && seen == 0) seen = i;
    end
    chk("rd_latency", 32'(seen), 32'(lat));
    chk("rd_hold", 32'(AD_OE), 32'd1);
    NOE = 1'b1;
    for (int i = 0; i < 10 && AD_OE; i++) @(negedge CLK);
    chk("rd_release", 32'(AD_OE), 32'd0);
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) @(negedge CLK);
    chk("rst_strobes", 32'({AD_OE, RAM_WE, FREQ_UPD, FIFO_RD}), 32'd0);
    chk("rst_freq", FREQ_WORD, 32'd0);
    chk("rst_ad_out", 32'(AD_OUT), 32'd0);
    RST_N = 1'b1;
    repeat (6) @(negedge CLK);
    chk("idle_outs", 32'({AD_OE, RAM_WE, FREQ_UPD, FIFO_RD, RAM_ADDR}), 32'd0);

    // RAM write
    ram_q.push_back({15'h0123, 16'hBEEF});
    bus_write(19'h50123, 16'hBEEF);
    chk("ram_we_count", 32'(ram_we_cnt), 32'd1);
    chk("ram_q_empty", 32'(ram_q.size()), 32'd0);

    // frequency word: low half alone must not commit
    bus_write(19'h58400, 16'h5678);
    chk("frewl_no_commit", FREQ_WORD, 32'd0);
    chk("frewl_no_upd", 32'(upd_cnt), 32'd0);
    freq_q.push_back(32'h12345678);
    bus_write(19'h58800, 16'h1234);
    chk("frewh_upd", 32'(upd_cnt), 32'd1);
    chk("frewh_word", FREQ_WORD, 32'h12345678);

    // FIFO read with data
    FIFO_DATA = 16'h0A0B; FIFO_EMPTY = 1'b0;
    rd_q.push_back(16'h0A0B);
    bus_read(19'h58001, 5);
    chk("fifo_rd_one", 32'(fifo_rd_cnt), 32'd1);

    // empty FIFO, and status reads at a non-FIFO address
    FIFO_EMPTY = 1'b1;
    rd_q.push_back(16'h0000);
    bus_read(19'h58001, 4);
    rd_q.push_back(16'h0004);
    bus_read(19'h58000, 4);
    FIFO_EMPTY = 1'b0;
    rd_q.push_back(16'h0000);
    bus_read(19'h58000, 4);
    chk("fifo_rd_none", 32'(fifo_rd_cnt), 32'd1);
    chk("rd_q_empty", 32'(rd_q.size()), 32'd0);

    // NADV fall while the write is waiting to sample: transaction dropped
    addr_phase(19'h50200);
    AD_IN = 16'h1111; NWE = 1'b0;
    @(negedge CLK);
    NADV = 1'b0;
    repeat (2) @(negedge CLK);
    NADV = 1'b1;
    repeat (10) @(negedge CLK);
    NWE = 1'b1;
    repeat (6) @(negedge CLK);
    chk("abort_no_we", 32'(ram_we_cnt), 32'd1);
    chk("abort_ram_port", 32'({RAM_ADDR, RAM_WDATA}), 32'({15'h0123, 16'hBEEF}));

    // unmapped write changes nothing
    bus_write(19'h12345, 16'hFFFF);
    chk("unmapped_cnts", 32'({ram_we_cnt[7:0], upd_cnt[7:0], fifo_rd_cnt[7:0]}), 32'h010101);
    chk("unmapped_ram", 32'({RAM_ADDR, RAM_WDATA}), 32'({15'h0123, 16'hBEEF}));
    chk("unmapped_freq", FREQ_WORD, 32'h12345678);
    chk("unmapped_ad", 32'({AD_OE, AD_OUT}), 32'd0);

    // simultaneous NWE/NOE: write wins (FREWL), no read
    addr_phase(19'h58400);
    AD_IN = 16'h9ABC; NWE = 1'b0; NOE = 1'b0;
    repeat (10) @(negedge CLK);
    chk("simul_no_oe", 32'(AD_OE), 32'd0);
    NWE = 1'b1; NOE = 1'b1;
    repeat (6) @(negedge CLK);
    freq_q.push_back(32'hDEF09ABC);
    bus_write(19'h58800, 16'hDEF0);
    // FREWH without a new FREWL reuses the old low half
    freq_q.push_back(32'h11119ABC);
    bus_write(19'h58800, 16'h1111);
    chk("freq_upd_total", 32'(upd_cnt), 32'd3);
    chk("freq_stale", FREQ_WORD, 32'h11119ABC);

    // reset during RD_DRIVE
    FIFO_DATA = 16'h0A0B; FIFO_EMPTY = 1'b0;
    rd_q.push_back(16'h0A0B);
    addr_phase(19'h58001);
    NOE = 1'b0;
    for (int i = 0; i < 12 && !AD_OE; i++) @(negedge CLK);
    chk("pre_rst_oe", 32'(AD_OE), 32'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_oe_async", 32'(AD_OE), 32'd0);
    chk("rst_freq_mid", FREQ_WORD, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1; NOE = 1'b1;
    repeat (8) @(negedge CLK);
    chk("post_rst_oe", 32'(AD_OE), 32'd0);
    rd_q.push_back(16'h0A0B);
    bus_read(19'h58001, 5);
    chk("post_rst_fifo_rd", 32'(fifo_rd_cnt), 32'd3);
    chk("sb_empty", 32'(ram_q.size() + freq_q.size() + rd_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsmc_bus_ctrl.md
Name: fsmc_bus_ctrl

Overview:
Synchronous front end for the MCU external bus (multiplexed AD[15:0], A16-A18, NADV/NWE/NOE). It resynchronises the bus strobes, latches and decodes the 19-bit address, and sequences three resources: DDS waveform RAM writes, the 32-bit DDS frequency word, and ADC FIFO reads back to the MCU. It replaces the edge-clocked latches with a single-clock FSM and sits between the MCU pins and the DDS and ADC blocks.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the NADV/NWE/NOE synchronisers (>=2)
WR_SAMPLE, 2, cycles after synced NWE fall before AD_IN is captured for a write
FIFO_LAT, 1, cycles from FIFO_RD pulse to valid FIFO_DATA

Ports:
CLK  in  1  system clock; the only clock
RST_N  in  1  asynchronous, active-low reset
NADV  in  1  MCU address-valid strobe, active low, asynchronous
NWE  in  1  MCU write strobe, active low, asynchronous
NOE  in  1  MCU read strobe, active low, asynchronous
A_HI  in  3  MCU address bits {A18,A17,A16}
AD_IN  in  16  AD bus input (address phase / write data)
AD_OUT  out  16  read data to the AD bus tristate buffer
AD_OE  out  1  tristate enable for AD_OUT
RAM_WE  out  1  one-cycle DDS RAM write strobe
RAM_ADDR  out  15  DDS RAM address (latched ADDR[14:0])
RAM_WDATA  out  16  DDS RAM write data
FREQ_WORD  out  32  committed DDS frequency word
FREQ_UPD  out  1  one-cycle pulse on FREQ_WORD change
FIFO_RD  out  1  one-cycle ADC FIFO read request
FIFO_DATA  in  16  ADC FIFO read data
FIFO_EMPTY  in  1  ADC FIFO empty flag

Behaviour:
- Reset: every output 0 (AD_OE=0, AD_OUT=0, FREQ_WORD=0). Latched address, shadow low word and synchronisers are cleared. FSM returns to IDLE asynchronously, including mid-transaction.
- Strobes pass through SYNC_STAGES flops. Edges are detected on the synced copies.
- Address latch: on synced NADV rising edge, ADDR <= {A_HI, AD_IN} sampled that cycle. The MCU holds the address for at least SYNC_STAGES+1 cycles.
- Decode (constants): RAM region when ADDR[18:15]==4'hA; FREWL=19'h58400; FREWH=19'h58800; FIFO=19'h58001. All other addresses are unmapped.
- FSM states: IDLE, WR_WAIT, WR_EXEC, RD_REQ, RD_WAIT, RD_DRIVE.
- IDLE to WR_WAIT: synced NWE fall.
- WR_WAIT: count WR_SAMPLE cycles, capture AD_IN into a data register, then go to WR_EXEC.
- WR_EXEC (one cycle), by decoded target:
  - RAM: RAM_WE=1, with RAM_ADDR/RAM_WDATA stable.
  - FREWL: shadow <= data.
  - FREWH: FREQ_WORD <= {data, shadow}, FREQ_UPD=1.
  - Unmapped: no effect.
  - Then wait in WR_EXEC (strobes low) until synced NWE high, then IDLE.
- FREWH without a prior FREWL commits the stale shadow; this is intended. FREQ_WORD never shows a half-updated value.
- IDLE to RD_REQ: synced NOE fall.
- RD_REQ, FIFO address and !FIFO_EMPTY: FIFO_RD=1 for one cycle, then RD_WAIT for FIFO_LAT cycles, then AD_OUT <= FIFO_DATA.
- RD_REQ, FIFO address and FIFO_EMPTY: no FIFO_RD; AD_OUT <= 16'h0000.
- RD_REQ, any other address: AD_OUT <= {13'b0, A-decoded status: FIFO_EMPTY, 2'b0}. This means bit 2 = FIFO_EMPTY, all other bits 0.
- RD_DRIVE: AD_OE=1 until synced NOE rises. Then AD_OE=0 on the next edge and the FSM returns to IDLE. Exactly one FIFO_RD per NOE low pulse.
- A synced NADV fall in any non-IDLE state aborts to IDLE. AD_OE drops and no further strobes are issued.
- Simultaneous NWE and NOE falls: the write wins.
- Read latency from synced NOE fall to AD_OE: 1 + 1 + FIFO_LAT cycles.

Decomposition:
- Package fsmc_pkg holds:
  - state enum
  - address constants ADDR_RAM_TAG, ADDR_FREWL, ADDR_FREWH, ADDR_FIFO
  - target enum {TGT_NONE, TGT_RAM, TGT_FREWL, TGT_FREWH, TGT_FIFO}
- Sub-module: fsmc_sync_edge (parametrised synchroniser with rise/fall pulse outputs), instanced three times.

Test Plan:
- Reset asserted mid-RD_DRIVE -> AD_OE=0 immediately, FREQ_WORD=0, FSM in IDLE after release.
- Address 0x50123, write 0xBEEF -> exactly one RAM_WE, RAM_ADDR=0x0123, RAM_WDATA=0xBEEF.
- Write 0x5678 to FREWL, then 0x1234 to FREWH -> FREQ_WORD unchanged after first write; 0x12345678 with a single FREQ_UPD pulse after second.
- FIFO preloaded with 0x0A0B, read at 0x58001 -> one FIFO_RD; AD_OUT=0x0A0B with AD_OE high until NOE returns high.
- FIFO_EMPTY=1, read at 0x58001 -> no FIFO_RD, AD_OUT=0x0000; read at 0x58000 -> AD_OUT=0x0004.
- NADV pulse during WR_WAIT, write to unmapped 0x12345 -> transaction aborted, no RAM_WE/FREQ_UPD; unmapped write leaves all outputs unchanged.
